controlador_operacoes: RTL
==========================

Name: controlador_operacoes

Overview:
Sequencing master for the 5x5 matrix memory. On a start pulse it reads matrices A (id 00) and B (id 01) element by element through the memory's we/re/id_matriz/linha/coluna port, computes C = A+B, A−B or A×B, and writes each result element into matrix C (id 10). It sits between the top-level command logic and the matrix memory, driving every memory input and consuming the memory's registered read data.

Parameters:
LARGURA, 16, data word width; must match the memory data width
N, 5, matrix dimension; fixed to the memory's 5x5 organisation

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request; sampled only in OCIOSO
op  in  2  00 soma, 01 subtracao, 10 multiplicacao, 11 invalid; latched when start is accepted
busy  out  1  high in every state except OCIOSO
done  out  1  one-cycle pulse in FIM
erro  out  1  one-cycle pulse in FIM when latched op = 11
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable
mem_id_matriz  out  2  matrix select
mem_linha  out  3  row index 0–4
mem_coluna  out  3  column index 0–4
mem_dado_wr  out  LARGURA  write data to memory
mem_dado_rd  in  LARGURA  memory read data; valid in the cycle after mem_re was sampled

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered (Moore). On rst, all outputs are 0, the state is OCIOSO, and counters i, j, k, the operand register opA and the accumulator acc are 0.
- mem_we and mem_re are never high in the same cycle.
- States: OCIOSO, LE_A, LE_B, CALC, ESCREVE, FIM.
- OCIOSO:
  - start=1 with op≠11: latch op, clear i, j, k and acc, go to LE_A.
  - start=1 with op=11: go directly to FIM with erro=1. There is no memory access.
- LE_A: mem_re=1, id=00.
  - Address is (i,j) for soma/subtracao and (i,k) for multiplicacao.
  - Next state is LE_B.
- LE_B: mem_re=1, id=01.
  - Address is (i,j) for soma/subtracao and (k,j) for multiplicacao.
  - Capture mem_dado_rd (the A element) into opA.
  - Next state is CALC.
- CALC: mem_dado_rd holds the B element.
  - soma: acc ← opA + B.
  - subtracao: acc ← opA − B.
  - multiplicacao: acc ← acc + low LARGURA bits of (opA × B).
  - For multiplicacao with k<4: k←k+1, go to LE_A. Otherwise go to ESCREVE.
- ESCREVE: mem_we=1, id=10, address (i,j), mem_dado_wr=acc.
  - Clear acc and k.
  - Advance in row-major order (j inner, i outer).
  - After (4,4), go to FIM; otherwise go to LE_A.
- FIM: done=1 (erro=1 if the latched op is 11). Next state is OCIOSO.
- Arithmetic is modulo 2^LARGURA; all results are truncated to LARGURA bits, so signed and unsigned interpretations give identical bit patterns.
- Latency (start sampled at edge 0):
  - soma/subtracao: 4 cycles per element, last ESCREVE in cycle 100, done in cycle 101.
  - multiplicacao: 16 cycles per element, done in cycle 401.
  - invalid op: done and erro in cycle 1.
- Exactly 25 mem_we pulses per valid operation, in row-major order.
- start while busy=1 is ignored, and op changes while busy have no effect.
- rst mid-operation aborts immediately and returns all outputs to 0. Already-written C elements are not rolled back.
- In non-write states mem_dado_wr = 0. In OCIOSO and FIM, mem_id_matriz, mem_linha and mem_coluna are 0.

Test Plan:
1. Assert rst for 3 cycles, then release -> all outputs 0 and busy=0. Pulse rst during the mem_re=1 of an operation -> outputs 0 in the same cycle, asynchronously.
2. Preload A all 0x0003 and B[i][j]=5i+j; start, op=00 -> C[i][j]=3+5i+j, 25 writes in row-major order, done in cycle 101, busy high in cycles 1–101.
3. Preload A all 0x0001 and B all 0x0002; start, op=01 -> C all 0xFFFF.
4. Preload A=identity and B[i][j]=5i+j+7; start, op=10 -> C=B with done in cycle 401. Preload A all 2 and B all 3 -> C all 0x001E. Preload A and B all 0x0100 -> C all 0x0000 (wrap).
5. Start op=00, then pulse start with op=10 in cycle 40 -> ignored, result is still A+B and done occurs once, in cycle 101.
6. Start with op=11 -> done=1 and erro=1 in cycle 1, busy=1 only in cycle 1, mem_we and mem_re never asserted, memory contents unchanged.

Source files
------------

// File: rtl/controlador_operacoes.sv
// Sequencing master for the 5x5 matrix memory: reads A and B, computes
// C = A+B, A-B or A*B element by element and writes the result into C.
module controlador_operacoes #(
  parameter int LARGURA = 16,
  parameter int N       = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  output logic               busy,
  output logic               done,
  output logic               erro,
  output logic               mem_we,
  output logic               mem_re,
  output logic [1:0]         mem_id_matriz,
  output logic [2:0]         mem_linha,
  output logic [2:0]         mem_coluna,
  output logic [LARGURA-1:0] mem_dado_wr,
  input  logic [LARGURA-1:0] mem_dado_rd
);

  typedef enum logic [2:0] {
    OCIOSO,
    LE_A,
    LE_B,
    CALC,
    ESCREVE,
    FIM
  } estado_t;

  localparam logic [1:0] OP_SOMA = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  localparam logic [1:0] ID_A = 2'b00;
  localparam logic [1:0] ID_B = 2'b01;
  localparam logic [1:0] ID_C = 2'b10;

  localparam logic [2:0] ULTIMO = 3'(N - 1);

  estado_t              estado, estado_n;
  logic [1:0]           op_q, op_n;
  logic [2:0]           i, j, k, i_n, j_n, k_n;
  logic [LARGURA-1:0]   op_a, op_a_n;
  logic [LARGURA-1:0]   acc, acc_n;
  logic [LARGURA-1:0]   prod_baixo;

  logic                 busy_n, done_n, erro_n, mem_we_n, mem_re_n;
  logic [1:0]           mem_id_n;
  logic [2:0]           mem_linha_n, mem_coluna_n;
  logic [LARGURA-1:0]   mem_dado_wr_n;

  // Truncated to LARGURA bits on purpose: only the low half feeds the accumulator.
  assign prod_baixo = op_a * mem_dado_rd;

  always_comb begin
    estado_n = estado;
    op_n     = op_q;
    i_n      = i;
    j_n      = j;
    k_n      = k;
    op_a_n   = op_a;
    acc_n    = acc;

    unique case (estado)
      OCIOSO: begin
        if (start) begin
          op_n = op;
          if (op == OP_INV) begin
            estado_n = FIM;
          end else begin
            i_n      = '0;
            j_n      = '0;
            k_n      = '0;
            acc_n    = '0;
            estado_n = LE_A;
          end
        end
      end
      LE_A: estado_n = LE_B;
      LE_B: begin
        op_a_n   = mem_dado_rd;
        estado_n = CALC;
      end
      CALC: begin
        unique case (op_q)
          OP_SOMA: acc_n = op_a + mem_dado_rd;
          OP_SUB:  acc_n = op_a - mem_dado_rd;
          default: acc_n = acc + prod_baixo;
        endcase
        if (op_q == OP_MUL && k != ULTIMO) begin
          k_n      = k + 3'd1;
          estado_n = LE_A;
        end else begin
          estado_n = ESCREVE;
        end
      end
      ESCREVE: begin
        acc_n = '0;
        k_n   = '0;
        if (j != ULTIMO) begin
          j_n      = j + 3'd1;
          estado_n = LE_A;
        end else if (i != ULTIMO) begin
          j_n      = '0;
          i_n      = i + 3'd1;
          estado_n = LE_A;
        end else begin
          j_n      = '0;
          i_n      = '0;
          estado_n = FIM;
        end
      end
      FIM:     estado_n = OCIOSO;
      default: estado_n = OCIOSO;
    endcase

    // Outputs are decoded from the next state so they can be registered alongside it.
    busy_n        = (estado_n != OCIOSO);
    done_n        = (estado_n == FIM);
    erro_n        = (estado_n == FIM) && (op_n == OP_INV);
    mem_we_n      = 1'b0;
    mem_re_n      = 1'b0;
    mem_id_n      = 2'b00;
    mem_linha_n   = 3'd0;
    mem_coluna_n  = 3'd0;
    mem_dado_wr_n = '0;

    unique case (estado_n)
      LE_A: begin
        mem_re_n     = 1'b1;
        mem_id_n     = ID_A;
        mem_linha_n  = i_n;
        mem_coluna_n = (op_n == OP_MUL) ? k_n : j_n;
      end
      LE_B: begin
        mem_re_n     = 1'b1;
        mem_id_n     = ID_B;
        mem_linha_n  = (op_n == OP_MUL) ? k_n : i_n;
        mem_coluna_n = j_n;
      end
      ESCREVE: begin
        mem_we_n      = 1'b1;
        mem_id_n      = ID_C;
        mem_linha_n   = i_n;
        mem_coluna_n  = j_n;
        mem_dado_wr_n = acc_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado        <= OCIOSO;
      op_q          <= 2'b00;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      op_a          <= '0;
      acc           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      erro          <= 1'b0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      mem_id_matriz <= 2'b00;
      mem_linha     <= 3'd0;
      mem_coluna    <= 3'd0;
      mem_dado_wr   <= '0;
    end else begin
      estado        <= estado_n;
      op_q          <= op_n;
      i             <= i_n;
      j             <= j_n;
      k             <= k_n;
      op_a          <= op_a_n;
      acc           <= acc_n;
      busy          <= busy_n;
      done          <= done_n;
      erro          <= erro_n;
      mem_we        <= mem_we_n;
      mem_re        <= mem_re_n;
      mem_id_matriz <= mem_id_n;
      mem_linha     <= mem_linha_n;
      mem_coluna    <= mem_coluna_n;
      mem_dado_wr   <= mem_dado_wr_n;
    end
  end

endmodule
